// File: rtl/button_event_decoder.sv
// Button event decoder.
// Turns a debounced button level into one-cycle event pulses: press, release,
// short click, long press and auto-repeat while held. A lockout state keeps a
// button that is already down (at reset or when enabled) silent until it has
// been seen released once.
module button_event_decoder #(
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic en,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [1:0] ST_LOCKOUT = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_HELD    = 2'd3;

  // Terminal counts: the counter restarts from 0 on every state entry and at
  // every threshold, so it never needs to count past these values.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // State, tick counter and registered outputs; pulses clear every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_LOCKOUT;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (!en) begin
        // Disabling aborts any press silently; no release is reported.
        state <= ST_LOCKOUT;
        cnt   <= '0;
        held  <= 1'b0;
      end else begin
        case (state)
          ST_LOCKOUT: begin
            if (!btn_level) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          ST_IDLE: begin
            if (btn_level) begin
              state       <= ST_PRESSED;
              press_pulse <= 1'b1;
              held        <= 1'b1;
              cnt         <= '0;
            end
          end
          ST_PRESSED: begin
            // A release on the threshold edge wins over the long press.
            if (!btn_level) begin
              state         <= ST_IDLE;
              release_pulse <= 1'b1;
              short_pulse   <= 1'b1;
              held          <= 1'b0;
              cnt           <= '0;
            end else if (cnt == LONG_LAST) begin
              state      <= ST_HELD;
              long_pulse <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            // A release on a repeat edge wins over the repeat.
            if (!btn_level) begin
              state         <= ST_IDLE;
              release_pulse <= 1'b1;
              held          <= 1'b0;
              cnt           <= '0;
            end else if (cnt == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_LOCKOUT;
            cnt   <= '0;
            held  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
